// File: rtl/cv32e40x_xif_result_queue_if.sv
// Handshake bundle for the XIF result queue: FU result input, commit/kill channel
// and eXtension-interface result channel. The queue itself uses the slave modport.
interface cv32e40x_xif_result_queue_if #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
);
    logic                   fu_valid;
    logic                   fu_ready;
    logic [X_ID_WIDTH-1:0]  fu_id;
    logic [4:0]             fu_rd;
    logic [X_RFW_WIDTH-1:0] fu_data;

    logic                   commit_valid;
    logic [X_ID_WIDTH-1:0]  commit_id;
    logic                   commit_kill;

    logic                   result_valid;
    logic                   result_ready;
    logic [X_ID_WIDTH-1:0]  result_id;
    logic [4:0]             result_rd;
    logic [X_RFW_WIDTH-1:0] result_data;
    logic                   result_we;

    modport master (
        output fu_valid, fu_id, fu_rd, fu_data,
        output commit_valid, commit_id, commit_kill,
        output result_ready,
        input  fu_ready,
        input  result_valid, result_id, result_rd, result_data, result_we
    );

    modport slave (
        input  fu_valid, fu_id, fu_rd, fu_data,
        input  commit_valid, commit_id, commit_kill,
        input  result_ready,
        output fu_ready,
        output result_valid, result_id, result_rd, result_data, result_we
    );
endinterface

// File: rtl/cv32e40x_xif_result_queue.sv
// In-order XIF result queue: holds FU results until their instruction commits, drops killed ones.
// Optional same-cycle commit bypass of the head: define CV32E40X_XIF_RESULT_QUEUE_COMMIT_BYPASS_EN.
module cv32e40x_xif_result_queue #(
    parameter int DEPTH       = 2,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input logic                        clk_i,
    input logic                        rst_n,
    cv32e40x_xif_result_queue_if.slave xif
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int NUM_IDS = 2 ** X_ID_WIDTH;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_WAIT,
        HEAD_SEND,
        HEAD_DROP
    } head_state_e;

    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, rptr_q, count_q;
    logic [NUM_IDS-1:0] committed_q, killed_q;
    logic [NUM_IDS-1:0] committed_d, killed_d;

    head_state_e           head_state;
    logic [IDX_W-1:0]      widx, ridx;
    logic [X_ID_WIDTH-1:0] head_id;
    logic                  full, push, pop, bypass_hit, result_valid;

    assign widx    = wptr_q[IDX_W-1:0];
    assign ridx    = rptr_q[IDX_W-1:0];
    assign head_id = id_q[ridx];

    // fu_ready depends only on registered count, so result_ready never reaches it.
    assign full = (count_q == FULL_CNT);
    assign push = xif.fu_valid && !full;

    always_comb begin
        head_state = HEAD_WAIT;
        if (count_q == '0) begin
            head_state = HEAD_EMPTY;
        end else if (killed_q[head_id]) begin
            head_state = HEAD_DROP;
        end else if (committed_q[head_id]) begin
            head_state = HEAD_SEND;
        end
    end

`ifdef CV32E40X_XIF_RESULT_QUEUE_COMMIT_BYPASS_EN
    assign bypass_hit = (head_state == HEAD_WAIT) && xif.commit_valid &&
                        !xif.commit_kill && (xif.commit_id == head_id);
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        result_valid = 1'b0;
        pop          = 1'b0;
        unique case (head_state)
            HEAD_SEND: begin
                result_valid = 1'b1;
                pop          = xif.result_ready;
            end
            HEAD_DROP: begin
                pop = 1'b1;
            end
            HEAD_WAIT: begin
                result_valid = bypass_hit;
                pop          = bypass_hit && xif.result_ready;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            id_q[widx]   <= xif.fu_id;
            rd_q[widx]   <= xif.fu_rd;
            data_q[widx] <= xif.fu_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + ONE;
            end
            if (pop) begin
                rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // A commit/kill arriving for an ID in the same cycle its old entry pops wins over the clear.
    always_comb begin
        committed_d = committed_q;
        killed_d    = killed_q;
        if (pop) begin
            committed_d[head_id] = 1'b0;
            killed_d[head_id]    = 1'b0;
        end
        if (xif.commit_valid) begin
            if (xif.commit_kill) begin
                killed_d[xif.commit_id] = 1'b1;
            end else begin
                committed_d[xif.commit_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            committed_q <= '0;
            killed_q    <= '0;
        end else begin
            committed_q <= committed_d;
            killed_q    <= killed_d;
        end
    end

    assign xif.fu_ready     = !full;
    assign xif.result_valid = result_valid;
    assign xif.result_we    = result_valid;
    assign xif.result_id    = head_id;
    assign xif.result_rd    = rd_q[ridx];
    assign xif.result_data  = data_q[ridx];

endmodule

// File: tb/tb_cv32e40x_xif_result_queue.sv
// Self-checking bench for cv32e40x_xif_result_queue: directed timing tests plus randomized
// commit/kill traffic checked by a scoreboard of the committed results in program order.
module tb_cv32e40x_xif_result_queue;

    localparam int DEPTH      = 2;
    localparam int IDW        = 4;
    localparam int DW         = 32;
    localparam int N_INSTR    = 200;
    localparam int WINDOW     = 8;
    localparam int MAX_CYCLES = 20000;

`ifdef CV32E40X_XIF_RESULT_QUEUE_COMMIT_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        int            seq;
        logic [IDW-1:0] id;
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   oldest;
    exp_t exp_q[$];

    logic [4:0]    rd_a   [N_INSTR];
    logic [DW-1:0] data_a [N_INSTR];
    logic          kill_a [N_INSTR];

    cv32e40x_xif_result_queue_if #(.X_ID_WIDTH(IDW), .X_RFW_WIDTH(DW)) xif ();

    cv32e40x_xif_result_queue #(
        .DEPTH      (DEPTH),
        .X_ID_WIDTH (IDW),
        .X_RFW_WIDTH(DW)
    ) dut (
        .clk_i(clk),
        .rst_n(rst_n),
        .xif  (xif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, returns at the falling edge for sampling.
    task automatic applyStimulus(input logic fv, input logic [IDW-1:0] fid, input logic [4:0] frd,
                                 input logic [DW-1:0] fdata, input logic cv, input logic [IDW-1:0] cid,
                                 input logic ck, input logic rr);
        @(posedge clk);
        #1;
        xif.fu_valid     = fv;
        xif.fu_id        = fid;
        xif.fu_rd        = frd;
        xif.fu_data      = fdata;
        xif.commit_valid = cv;
        xif.commit_id    = cid;
        xif.commit_kill  = ck;
        xif.result_ready = rr;
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, rr);
    endtask

    task automatic expectResult(input logic [IDW-1:0] id, input logic [4:0] rd, input logic [DW-1:0] data);
        exp_t e;
        e.seq  = 0;
        e.id   = id;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every result handshake must match the oldest outstanding committed result.
    initial begin : monitor
        logic           prev_hold;
        logic [IDW-1:0] prev_id;
        logic [DW-1:0]  prev_data;
        exp_t           e;
        prev_hold = 1'b0;
        prev_id   = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checks++;
                    if (!(xif.result_valid === 1'b1 && xif.result_id === prev_id && xif.result_data === prev_data)) begin
                        failures++;
                        $display("[TB] FAIL hold_stable: got valid=%0b id=%0d data=0x%0h, expected valid=1 id=%0d data=0x%0h",
                                 xif.result_valid, xif.result_id, xif.result_data, prev_id, prev_data);
                    end
                end
                if (xif.result_valid === 1'b1 && xif.result_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_result: got id=%0d data=0x%0h, expected no result",
                                 xif.result_id, xif.result_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (xif.result_id !== e.id || xif.result_rd !== e.rd ||
                            xif.result_data !== e.data || xif.result_we !== 1'b1) begin
                            failures++;
                            $display("[TB] FAIL result_order: got id=%0d rd=%0d data=0x%0h we=%0b, expected id=%0d rd=%0d data=0x%0h we=1",
                                     xif.result_id, xif.result_rd, xif.result_data, xif.result_we, e.id, e.rd, e.data);
                        end
                        oldest = e.seq + 1;
                    end
                    prev_hold = 1'b0;
                end else if (xif.result_valid === 1'b1) begin
                    prev_hold = 1'b1;
                    prev_id   = xif.result_id;
                    prev_data = xif.result_data;
                end else begin
                    prev_hold = 1'b0;
                end
            end
        end
    end

    task automatic test_reset_idle();
        idle(1'b1);
        checkOutput("reset_valid", xif.result_valid, 0);
        checkOutput("reset_we", xif.result_we, 0);
        checkOutput("reset_fu_ready", xif.fu_ready, 1);
        checkOutput("reset_id", xif.result_id, 0);
        checkOutput("reset_rd", xif.result_rd, 0);
        checkOutput("reset_data", xif.result_data, 0);
    endtask

    task automatic test_commit_after_push();
        expectResult(4'd3, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("cap_c0_valid", xif.result_valid, 0);
        idle(1'b1);
        checkOutput("cap_c1_valid", xif.result_valid, 0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b1);
        checkOutput("cap_c2_valid", xif.result_valid, BYP);
`ifdef CV32E40X_XIF_RESULT_QUEUE_COMMIT_BYPASS_EN
        checkOutput("cap_c2_id", xif.result_id, 3);
        checkOutput("cap_c2_rd", xif.result_rd, 5);
        checkOutput("cap_c2_data", xif.result_data, 32'hDEADBEEF);
`endif
        idle(1'b1);
        checkOutput("cap_c3_valid", xif.result_valid, !BYP);
`ifndef CV32E40X_XIF_RESULT_QUEUE_COMMIT_BYPASS_EN
        checkOutput("cap_c3_id", xif.result_id, 3);
        checkOutput("cap_c3_rd", xif.result_rd, 5);
        checkOutput("cap_c3_data", xif.result_data, 32'hDEADBEEF);
        checkOutput("cap_c3_we", xif.result_we, 1);
`endif
        idle(1'b1);
        checkOutput("cap_c4_valid", xif.result_valid, 0);
        checkOutput("cap_c4_fu_ready", xif.fu_ready, 1);
    endtask

    task automatic test_commit_before_push();
        expectResult(4'd7, 5'd2, 32'h1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0, 1'b1);
        checkOutput("cbp_c0_valid", xif.result_valid, 0);
        idle(1'b1);
        idle(1'b1);
        applyStimulus(1'b1, 4'd7, 5'd2, 32'h1, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("cbp_c3_valid", xif.result_valid, 0);
        idle(1'b1);
        checkOutput("cbp_c4_valid", xif.result_valid, 1);
        checkOutput("cbp_c4_id", xif.result_id, 7);
        checkOutput("cbp_c4_data", xif.result_data, 1);
        idle(1'b1);
        checkOutput("cbp_c5_valid", xif.result_valid, 0);
        // Reuse of ID 7 without a fresh commit must not produce a result.
        applyStimulus(1'b1, 4'd7, 5'd2, 32'h2, 1'b0, '0, 1'b0, 1'b1);
        idle(1'b1);
        checkOutput("cbp_reuse_c1_valid", xif.result_valid, 0);
        idle(1'b1);
        checkOutput("cbp_reuse_c2_valid", xif.result_valid, 0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b1, 1'b1);
        checkOutput("cbp_kill_valid", xif.result_valid, 0);
        idle(1'b1);
        checkOutput("cbp_drop_valid", xif.result_valid, 0);
        idle(1'b1);
        checkOutput("cbp_after_drop_fu_ready", xif.fu_ready, 1);
    endtask

    task automatic test_full_kill_commit();
        expectResult(4'd2, 5'd12, 32'h2222_0002);
        applyStimulus(1'b1, 4'd1, 5'd11, 32'h1111_0001, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd2, 5'd12, 32'h2222_0002, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd4, 5'd14, 32'h4444_0004, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("full_c2_fu_ready", xif.fu_ready, 0);
        applyStimulus(1'b1, 4'd4, 5'd14, 32'h4444_0004, 1'b1, 4'd1, 1'b1, 1'b1);
        checkOutput("full_c3_fu_ready", xif.fu_ready, 0);
        checkOutput("full_c3_valid", xif.result_valid, 0);
        applyStimulus(1'b1, 4'd4, 5'd14, 32'h4444_0004, 1'b1, 4'd2, 1'b0, 1'b1);
        checkOutput("full_c4_fu_ready", xif.fu_ready, 0);
        checkOutput("full_c4_drop_valid", xif.result_valid, 0);
        applyStimulus(1'b1, 4'd4, 5'd14, 32'h4444_0004, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("full_c5_fu_ready", xif.fu_ready, 1);
        checkOutput("full_c5_valid", xif.result_valid, 1);
        checkOutput("full_c5_id", xif.result_id, 2);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd4, 1'b1, 1'b1);
        checkOutput("full_c6_valid", xif.result_valid, 0);
        checkOutput("full_c6_head_id", xif.result_id, 4);
        idle(1'b1);
        checkOutput("full_c7_drop_valid", xif.result_valid, 0);
        idle(1'b1);
        checkOutput("full_c8_fu_ready", xif.fu_ready, 1);
    endtask

    task automatic test_backpressure();
        expectResult(4'd1, 5'd1, 32'hA000_0001);
        expectResult(4'd2, 5'd2, 32'hA000_0002);
        expectResult(4'd3, 5'd3, 32'hA000_0003);
        applyStimulus(1'b1, 4'd1, 5'd1, 32'hA000_0001, 1'b1, 4'd1, 1'b0, 1'b0);
        checkOutput("bp_c0_valid", xif.result_valid, 0);
        applyStimulus(1'b1, 4'd2, 5'd2, 32'hA000_0002, 1'b1, 4'd2, 1'b0, 1'b0);
        checkOutput("bp_c1_id", xif.result_id, 1);
        applyStimulus(1'b1, 4'd3, 5'd3, 32'hA000_0003, 1'b1, 4'd3, 1'b0, 1'b0);
        checkOutput("bp_c2_id", xif.result_id, 1);
        checkOutput("bp_c2_fu_ready", xif.fu_ready, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4'd3, 5'd3, 32'hA000_0003, 1'b0, '0, 1'b0, 1'b0);
            checkOutput("bp_hold_valid", xif.result_valid, 1);
            checkOutput("bp_hold_data", xif.result_data, 32'hA000_0001);
        end
        applyStimulus(1'b1, 4'd3, 5'd3, 32'hA000_0003, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("bp_r0_id", xif.result_id, 1);
        applyStimulus(1'b1, 4'd3, 5'd3, 32'hA000_0003, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("bp_r1_valid", xif.result_valid, 1);
        checkOutput("bp_r1_id", xif.result_id, 2);
        checkOutput("bp_r1_fu_ready", xif.fu_ready, 1);
        idle(1'b1);
        checkOutput("bp_r2_valid", xif.result_valid, 1);
        checkOutput("bp_r2_id", xif.result_id, 3);
        idle(1'b1);
        checkOutput("bp_r3_valid", xif.result_valid, 0);
    endtask

    task automatic test_async_reset();
        expectResult(4'd9, 5'd9, 32'h9999_0009);
        applyStimulus(1'b1, 4'd9, 5'd9, 32'h9999_0009, 1'b1, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd10, 5'd10, 32'h1010_0010, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("ar_pre_valid", xif.result_valid, 1);
        @(posedge clk);
        #2;
        rst_n            = 1'b0;
        xif.fu_valid     = 1'b0;
        xif.commit_valid = 1'b0;
        xif.result_ready = 1'b1;
        #1;
        checkOutput("ar_valid_drops", xif.result_valid, 0);
        checkOutput("ar_fu_ready", xif.fu_ready, 1);
        checkOutput("ar_data_zero", xif.result_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd9, 5'd9, 32'h9999_1111, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("ar_repush_c0_valid", xif.result_valid, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkOutput("ar_no_stale_commit", xif.result_valid, 0);
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("ar_clean_valid", xif.result_valid, 0);
        checkOutput("ar_clean_fu_ready", xif.fu_ready, 1);
    endtask

    // Instruction n uses ID n mod 16; at most WINDOW instructions are outstanding, so an ID is only
    // reused after its previous result has left the queue. Every 4th instruction commits so killed
    // ones are always followed by an observable retirement.
    task automatic run_random();
        int   np;
        int   nc;
        int   cyc;
        logic accepted;
        exp_t e;
        for (int i = 0; i < N_INSTR; i++) begin
            rd_a[i]   = 5'($urandom_range(0, 31));
            data_a[i] = $urandom;
            kill_a[i] = (i % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
        end
        checkOutput("random_start_empty", exp_q.size(), 0);
        np       = 0;
        nc       = 0;
        cyc      = 0;
        accepted = 1'b0;
        oldest   = 0;
        while (!(np == N_INSTR && nc == N_INSTR && oldest == N_INSTR) && cyc < MAX_CYCLES) begin
            @(posedge clk);
            #1;
            if (!xif.fu_valid || accepted) begin
                if (np < N_INSTR && np < oldest + WINDOW && $urandom_range(0, 99) < 65) begin
                    xif.fu_valid = 1'b1;
                    xif.fu_id    = 4'(np % 16);
                    xif.fu_rd    = rd_a[np];
                    xif.fu_data  = data_a[np];
                end else begin
                    xif.fu_valid = 1'b0;
                end
            end
            if (nc < N_INSTR && nc < oldest + WINDOW && $urandom_range(0, 99) < 50) begin
                xif.commit_valid = 1'b1;
                xif.commit_id    = 4'(nc % 16);
                xif.commit_kill  = kill_a[nc];
                nc++;
            end else begin
                xif.commit_valid = 1'b0;
            end
            xif.result_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            accepted = xif.fu_valid && xif.fu_ready;
            if (accepted) begin
                if (!kill_a[np]) begin
                    e.seq  = np;
                    e.id   = 4'(np % 16);
                    e.rd   = rd_a[np];
                    e.data = data_a[np];
                    exp_q.push_back(e);
                end
                np++;
            end
            cyc++;
        end
        checkOutput("random_completed_in_budget", (cyc < MAX_CYCLES), 1);
        checkOutput("random_all_retired", oldest, N_INSTR);
        idle(1'b1);
        idle(1'b1);
        checkOutput("random_drain_valid", xif.result_valid, 0);
        checkOutput("random_drain_fu_ready", xif.fu_ready, 1);
        checkOutput("random_scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        oldest           = 0;
        rst_n            = 1'b0;
        xif.fu_valid     = 1'b0;
        xif.fu_id        = '0;
        xif.fu_rd        = '0;
        xif.fu_data      = '0;
        xif.commit_valid = 1'b0;
        xif.commit_id    = '0;
        xif.commit_kill  = 1'b0;
        xif.result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        $display("[TB] reset and idle");
        test_reset_idle();
        $display("[TB] commit after push");
        test_commit_after_push();
        $display("[TB] commit before push");
        test_commit_before_push();
        $display("[TB] full queue with kill and commit");
        test_full_kill_commit();
        $display("[TB] result back-pressure");
        test_backpressure();
        $display("[TB] asynchronous reset mid-operation");
        test_async_reset();
        $display("[TB] randomized commit/kill traffic");
        run_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        failures++;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
